// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: instruction fetch for the OTTER core.
// Issues word addresses to a synchronous instruction memory and
// presents the returned instruction, with its PC, to decode.
//
// Ports:
//   CLK, RESET         clock, synchronous active-high reset
//   STALL              decode cannot accept; hold everything
//   FLUSH, REDIRECT_PC redirect fetch, squash the in-flight word
//   MEM_DOUT1          memory read data (one cycle after address)
//   MEM_ADDR1          word address = fetch PC [15:2]
//   MEM_RDEN1          memory read enable
//   IF_IR, IF_PC       instruction and its PC for decode
//   IF_NEXT_PC         IF_PC + 4 (link value)
//   IF_VALID           IF_IR/IF_PC carry a real instruction
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] REDIRECT_PC,
  input  logic [31:0] MEM_DOUT1,
  output logic [13:0] MEM_ADDR1,
  output logic        MEM_RDEN1,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_NEXT_PC,
  output logic        IF_VALID
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] hir_q, hir_d;
  logic        ov_q, ov_d;
  logic        hf_q, hf_d;

  logic do_flush, do_stall, do_adv;

  assign do_flush = FLUSH;
  assign do_stall = STALL & ~FLUSH;
  assign do_adv   = ~STALL & ~FLUSH;

  always_comb begin
    fpc_d = fpc_q;
    opc_d = opc_q;
    hir_d = hir_q;
    ov_d  = ov_q;
    hf_d  = hf_q;
    unique case (1'b1)
      do_flush: begin
        fpc_d = REDIRECT_PC & ~32'd3;
        ov_d  = 1'b0;
        hf_d  = 1'b0;
      end
      do_stall: begin
        // Memory output is not kept while its read
        // enable is low, so latch it on the first
        // stalled cycle and present the copy after.
        if (!hf_q) begin
          hir_d = MEM_DOUT1;
          hf_d  = 1'b1;
        end
      end
      do_adv: begin
        fpc_d = fpc_q + 32'd4;
        opc_d = fpc_q;
        ov_d  = 1'b1;
        hf_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fpc_q <= RESET_VEC;
      opc_q <= RESET_VEC;
      hir_q <= NOP_INSTR;
      ov_q  <= 1'b0;
      hf_q  <= 1'b0;
    end else begin
      fpc_q <= fpc_d;
      opc_q <= opc_d;
      hir_q <= hir_d;
      ov_q  <= ov_d;
      hf_q  <= hf_d;
    end
  end

  assign MEM_ADDR1  = fpc_q[15:2];
  assign MEM_RDEN1  = ~do_stall;
  assign IF_PC      = opc_q;
  assign IF_NEXT_PC = opc_q + 32'd4;
  assign IF_VALID   = ov_q;

  always_comb begin
    IF_IR = MEM_DOUT1;
    if (!ov_q)
      IF_IR = NOP_INSTR;
    else if (hf_q)
      IF_IR = hir_q;
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb_otter_fetch_stage: directed vector table plus a randomized
// run against a PC-level reference model of the fetch stage.
module tb_otter_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redir = '0;
  logic [31:0] mem_dout = '0;
  logic [13:0] addr;
  logic        rden;
  logic [31:0] ir, pc, npc;
  logic        valid;

  int checks = 0;
  int errors = 0;

  otter_fetch_stage #(
    .RESET_VEC(RV),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .STALL(stall),
    .FLUSH(flush),
    .REDIRECT_PC(redir),
    .MEM_DOUT1(mem_dout),
    .MEM_ADDR1(addr),
    .MEM_RDEN1(rden),
    .IF_IR(ir),
    .IF_PC(pc),
    .IF_NEXT_PC(npc),
    .IF_VALID(valid)
  );

  always #5 clk = ~clk;

  // Instruction stored at each word address carries its address.
  function automatic logic [31:0] tag(input logic [13:0] a);
    return {16'hC0DE, a, 2'b11};
  endfunction

  // Synchronous memory; output is junk when not read.
  always @(posedge clk) begin
    if (rden) mem_dout <= tag(addr);
    else      mem_dout <= $urandom;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic [31:0] rd;
    logic        ev;
    logic [31:0] epc;
    logic [13:0] ea;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s,
                     input logic f, input logic [31:0] rd,
                     input logic ev, input logic [31:0] epc,
                     input logic [13:0] ea, input logic er);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.rd = rd;
    v.ev = ev; v.epc = epc; v.ea = ea; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic f, input logic [31:0] rd);
    @(negedge clk);
    rst = r; stall = s; flush = f; redir = rd;
    #1;
  endtask

  task automatic check_all(input string p,
                           input logic ev,
                           input logic [31:0] epc,
                           input logic [13:0] ea,
                           input logic er);
    logic [31:0] eir;
    eir = ev ? tag(epc[15:2]) : NOP;
    check({p, " valid"}, {31'd0, valid}, {31'd0, ev});
    check({p, " pc"}, pc, epc);
    check({p, " next_pc"}, npc, epc + 32'd4);
    check({p, " ir"}, ir, eir);
    check({p, " addr"}, {18'd0, addr}, {18'd0, ea});
    check({p, " rden"}, {31'd0, rden}, {31'd0, er});
  endtask

  // Reference model state, in PC terms only.
  logic [31:0] m_fpc, m_opc;
  logic        m_ov;

  initial begin
    // r  s  f  redirect       v  pc             addr     rden
    add(1, 0, 0, 32'h0,        0, 32'h0,         14'h000, 1);
    add(0, 0, 0, 32'h0,        0, 32'h0,         14'h000, 1);
    add(0, 0, 0, 32'h0,        1, 32'h0,         14'h001, 1);
    add(0, 0, 0, 32'h0,        1, 32'h4,         14'h002, 1);
    add(0, 1, 0, 32'h0,        1, 32'h8,         14'h003, 0);
    add(0, 1, 0, 32'h0,        1, 32'h8,         14'h003, 0);
    add(0, 1, 0, 32'h0,        1, 32'h8,         14'h003, 0);
    add(0, 0, 0, 32'h0,        1, 32'h8,         14'h003, 1);
    add(0, 0, 1, 32'h103,      1, 32'hC,         14'h004, 1);
    add(0, 0, 0, 32'h0,        0, 32'hC,         14'h040, 1);
    add(0, 1, 0, 32'h0,        1, 32'h100,       14'h041, 0);
    add(0, 1, 1, 32'h21,       1, 32'h100,       14'h041, 1);
    add(0, 0, 0, 32'h0,        0, 32'h100,       14'h008, 1);
    add(0, 0, 1, 32'hFFFFFFFE, 1, 32'h20,        14'h009, 1);
    add(0, 0, 0, 32'h0,        0, 32'h20,        14'h3FFF, 1);
    add(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC,  14'h000, 1);
    add(0, 1, 0, 32'h0,        1, 32'h0,         14'h001, 0);
    add(1, 1, 0, 32'h0,        1, 32'h0,         14'h001, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         14'h000, 1);
    add(0, 0, 1, 32'h40,       1, 32'h0,         14'h001, 1);
    add(0, 1, 0, 32'h0,        0, 32'h0,         14'h010, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,         14'h010, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,         14'h010, 1);
    add(0, 0, 0, 32'h0,        1, 32'h40,        14'h011, 1);

    // Bring state out of X before the first checked row.
    drive(1, 0, 0, 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].rd);
      check_all($sformatf("vec%0d", i),
                tbl[i].ev, tbl[i].epc, tbl[i].ea, tbl[i].er);
    end

    drive(1, 0, 0, 32'h0);
    m_fpc = RV;
    m_opc = RV;
    m_ov  = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      logic r, s, f;
      logic [31:0] rd;
      r  = ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = $urandom;
      if ($urandom_range(0, 3) == 0)
        rd = 32'hFFFF_FFF0 | (rd & 32'hF);
      drive(r, s, f, rd);
      check_all($sformatf("rnd%0d", i), m_ov, m_opc,
                m_fpc[15:2], !(s && !f));
      if (r) begin
        m_fpc = RV;
        m_opc = RV;
        m_ov  = 1'b0;
      end else if (f) begin
        m_fpc = {rd[31:2], 2'b00};
        m_ov  = 1'b0;
      end else if (!s) begin
        m_opc = m_fpc;
        m_fpc = m_fpc + 32'd4;
        m_ov  = 1'b1;
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_fetch_stage.md
OTTER_FETCH_STAGE -- requirements
Module: otter_fetch_stage

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction driven when no valid fetch is present.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 STALL  in  1  decode cannot accept; hold PC and presented instruction.
REQ-006 FLUSH  in  1  redirect fetch to REDIRECT_PC; squash in-flight fetch.
REQ-007 REDIRECT_PC  in  32  branch/jump target, sampled when FLUSH=1.
REQ-008 MEM_DOUT1  in  32  instruction memory read data, valid one cycle after address.
REQ-009 MEM_ADDR1  out  14  instruction word address, equal to fetch PC bits [15:2].
REQ-010 MEM_RDEN1  out  1  instruction memory read enable.
REQ-011 IF_IR  out  32  instruction presented to decode.
REQ-012 IF_PC  out  32  PC of IF_IR.
REQ-013 IF_NEXT_PC  out  32  IF_PC + 4, for link values.
REQ-014 IF_VALID  out  1  IF_IR/IF_PC hold a real instruction.

Function
REQ-015 The block SHALL hold internal state: fetch PC (fpc), presented PC (opc), presented-valid (ov), hold register (hir), holding flag (hf).
REQ-016 MEM_ADDR1 SHALL equal fpc[15:2] combinationally every cycle.
REQ-017 MEM_RDEN1 SHALL be 0 when STALL=1 and FLUSH=0, else 1.
REQ-018 Advance (RESET=0, FLUSH=0, STALL=0): fpc <= fpc+4 (mod 2^32), opc <= fpc, ov <= 1, hf <= 0.
REQ-019 Stall (RESET=0, FLUSH=0, STALL=1): fpc, opc, ov hold; if hf=0 then hir <= MEM_DOUT1 and hf <= 1; if hf=1 then hir holds.
REQ-020 Flush (RESET=0, FLUSH=1): fpc <= {REDIRECT_PC[31:2],2'b00}, ov <= 0, hf <= 0, opc holds; FLUSH SHALL take priority over STALL.
REQ-021 IF_PC SHALL equal opc; IF_NEXT_PC SHALL equal opc+4 (mod 2^32).
REQ-022 IF_VALID SHALL equal ov.
REQ-023 IF_IR SHALL be NOP_INSTR when ov=0, hir when ov=1 and hf=1, else MEM_DOUT1.
REQ-024 Fetch latency: an address issued at cycle n SHALL be presented on IF_IR/IF_PC in cycle n+1 unless squashed by FLUSH at cycle n.
REQ-025 Redirect penalty: FLUSH at cycle n SHALL give IF_VALID=0 at n+1 and the target instruction with IF_VALID=1 at n+2 (absent stall).
REQ-026 An instruction presented during a stall SHALL remain bit-identical on IF_IR/IF_PC for every stall cycle and for the first cycle after STALL falls.
REQ-027 STALL with ov=0 SHALL keep IF_VALID=0 and IF_IR=NOP_INSTR.
REQ-028 fpc increment past 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000; MEM_ADDR1 wraps with fpc[15:2].
REQ-029 REDIRECT_PC[1:0] SHALL be ignored.

Reset
REQ-030 RESET=1 at a rising edge SHALL set fpc=RESET_VEC, opc=RESET_VEC, ov=0, hf=0, hir=NOP_INSTR, overriding FLUSH and STALL.
REQ-031 During and in the cycle after reset, IF_VALID=0, IF_IR=NOP_INSTR, MEM_ADDR1=RESET_VEC[15:2], MEM_RDEN1=1 (if STALL=0).
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard held instruction and pending redirect.

Verification
REQ-033 Reset release, STALL=FLUSH=0, memory returns addr-tagged data -> IF_PC sequence 0,4,8,12 from 2nd cycle after release, IF_VALID=1, IF_NEXT_PC=IF_PC+4.
REQ-034 Stall 3 cycles while IF_PC=8 -> IF_PC=8, IF_IR=instr(8) for all 3 cycles and next cycle, MEM_RDEN1=0 during stall, then IF_PC=12.
REQ-035 FLUSH with REDIRECT_PC=32'h0000_0103 at cycle n -> MEM_ADDR1=14'h040 at n+1, IF_VALID=0 at n+1, IF_PC=32'h100 IF_VALID=1 at n+2.
REQ-036 FLUSH and STALL both high -> flush behaviour of REQ-020, hold register discarded.
REQ-037 Redirect to 32'hFFFF_FFFC, run 2 cycles -> IF_PC=32'hFFFF_FFFC then 32'h0000_0000, IF_NEXT_PC wraps to 0.
REQ-038 RESET asserted during a 2-cycle stall -> next cycle IF_VALID=0, IF_IR=32'h0000_0013, MEM_ADDR1=RESET_VEC[15:2].
